// File: rtl/sm_hex_display_scan_pkg.sv
// Shared types and constants for the hex display scanner: state encoding,
// the active-high gfedcba decode table and the blank segment pattern.
package sm_display_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return HEX7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/sm_hex_display_scan_if.sv
// Bus between the register source and the display scanner.
// Handshake: data is taken in any cycle where dataValid=1 and hold=0; there is
// no back-pressure, so the source treats each dataValid cycle as consumed.
interface sm_hex_display_scan_if
  import sm_display_pkg::*;
#(
  parameter int DIGITS = 8
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] data;
  logic                dataValid;
  logic                hold;
  logic                blankEn;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   digit;
  logic                updated;

  // Internal scanner state, exported for observation.
  state_e              dbg_state;
  logic [IW-1:0]       dbg_idx;
  logic [4*DIGITS-1:0] dbg_cap;

  modport master (
    output data, dataValid, hold, blankEn,
    input  seg, dp, digit, updated, dbg_state, dbg_idx, dbg_cap
  );

  modport slave (
    input  data, dataValid, hold, blankEn,
    output seg, dp, digit, updated, dbg_state, dbg_idx, dbg_cap
  );

endinterface

// File: rtl/sm_hex_display_scan_hex_to_seg.sv
// Combinational nibble to 7-segment decoder, active-high gfedcba.
module sm_hex_to_seg
  import sm_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nibble_i);

endmodule

// File: rtl/sm_hex_display_scan.sv
// Time-multiplexed hex display driver: captures a word, scans one digit at a
// time with an all-off gap between digits, and blanks leading zeros on request.
module sm_hex_display_scan
  import sm_display_pkg::*;
#(
  parameter int DIGITS           = 8,
  parameter int SCAN_SHIFT       = 10,
  parameter int GAP_CYCLES       = 2,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  sm_hex_display_scan_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = 4 * DIGITS;

  localparam logic [3:0]        GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE  = DIGITS'(1);
  localparam logic [6:0]        SEG_POL  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_POL  = {DIGITS{DIGIT_ACTIVE_LOW}};

  logic [DW-1:0]         cap_q, cap_d;
  logic                  updated_q, updated_d;
  logic                  capture;

  state_e                state_q;
  logic [SCAN_SHIFT-1:0] pre_q;
  logic [3:0]            gc_q;
  logic [IW-1:0]         idx_q;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [DIGITS-1:0]     digit_q;

  logic [3:0]            nib;
  logic [IW-1:0]         msd;
  logic                  blank;
  logic [6:0]            seg_hex;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [DIGITS-1:0]     digit_n;

  // Capture and change detection.
  always_comb begin
    capture   = bus.dataValid && !bus.hold;
    cap_d     = capture ? bus.data : cap_q;
    updated_d = capture && (bus.data != cap_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q     <= '0;
      updated_q <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      updated_q <= updated_d;
    end
  end

  // Current nibble and most significant nonzero nibble (ascending loop keeps the highest).
  always_comb begin
    nib = 4'h0;
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) nib = cap_q[4*i +: 4];
      if (cap_q[4*i +: 4] != 4'h0) msd = IW'(i);
    end
    blank = bus.blankEn && (idx_q > msd);
  end

  sm_hex_to_seg u_dec (
    .nibble_i (nib),
    .seg_o    (seg_hex)
  );

  always_comb begin
    seg_n   = SEG_OFF;
    digit_n = '0;
    dp_n    = 1'b0;
    if (state_q == SHOW) begin
      digit_n = DIG_ONE << idx_q;
      seg_n   = blank ? SEG_OFF : seg_hex;
      dp_n    = (idx_q == '0) && bus.hold;
    end
  end

  // Scan FSM with its output register; polarity is applied only here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SHOW;
      pre_q   <= '0;
      gc_q    <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_POL;
      dp_q    <= SEG_ACTIVE_LOW;
      digit_q <= DIG_POL;
    end else begin
      seg_q   <= seg_n ^ SEG_POL;
      dp_q    <= dp_n ^ SEG_ACTIVE_LOW;
      digit_q <= digit_n ^ DIG_POL;
      case (state_q)
        SHOW: begin
          if (&pre_q) begin
            pre_q   <= '0;
            gc_q    <= '0;
            state_q <= GAP;
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
        GAP: begin
          gc_q <= gc_q + 1'b1;
          if (gc_q == GAP_LAST) begin
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            state_q <= SHOW;
          end
        end
        default: state_q <= SHOW;
      endcase
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit     = digit_q;
  assign bus.updated   = updated_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_idx   = idx_q;
  assign bus.dbg_cap   = cap_q;

endmodule

// File: doc/sm_hex_display_scan.md
# sm_hex_display_scan

Time-multiplexed 7-segment driver for the board's register-view output. It sits directly downstream of the CPU top: it samples the 32-bit `regData` word on the board clock and scans it out digit by digit onto a shared segment bus. It adds leading-zero blanking, an anti-ghosting gap between digits, and a hold/freeze control. It runs on the undivided board clock, so display refresh is independent of the CPU clock divider setting.

## Interface
Parameters:
- `DIGITS`, 8: number of hex digits; data width is 4*DIGITS.
- `SCAN_SHIFT`, 10: SHOW phase length per digit is 2^SCAN_SHIFT cycles.
- `GAP_CYCLES`, 2: all-digits-off cycles between digits; legal range 1..15.
- `SEG_ACTIVE_LOW`, 1: invert `seg`/`dp` at the output register.
- `DIGIT_ACTIVE_LOW`, 1: invert `digit` at the output register.

Ports:
- `clk` in 1: board clock. One clock; reset is synchronous and active-low (`rst_n`).
- `rst_n` in 1: synchronous active-low reset.
- `data` in 4*DIGITS: value to display; nibble i drives digit i, digit 0 is least significant.
- `dataValid` in 1: capture strobe, sampled each cycle.
- `hold` in 1: freeze the displayed value when 1.
- `blankEn` in 1: enables leading-zero blanking.
- `seg` out 7: segments {g,f,e,d,c,b,a}, registered.
- `dp` out 1: decimal point, registered.
- `digit` out DIGITS: one-hot digit enable, registered.
- `updated` out 1: one-cycle pulse when the captured value changes.

## Operation
- **Capture register `cap`**: `cap <= data` when `dataValid && !hold`. Otherwise `cap` holds its value.
- **`updated`**: registered. It is 1 in the cycle after a capture whose new value differs from the old `cap`. Otherwise it is 0.
- **FSM** has two states, SHOW and GAP. Support registers: prescaler `pre` (SCAN_SHIFT bits), gap counter `gc` (4 bits), digit index `idx` (clog2(DIGITS) bits).
  - SHOW: `pre` increments every cycle. When `pre` is all-ones: `pre <= 0`, `gc <= 0`, go to GAP.
  - GAP: `gc` increments every cycle. When `gc == GAP_CYCLES-1`: `idx` advances (DIGITS-1 wraps to 0), go to SHOW.
- **Leading-zero blanking**:
  - `msd` = index of the most significant nonzero nibble of `cap`; `msd` = 0 if `cap` is 0.
  - If `blankEn` is 1, digit `idx` is blanked when `idx > msd`.
  - Digit 0 is never blanked.
- **Next-output logic**:
  - In SHOW with digit not blanked: `digit` = onehot(`idx`), `seg` = hex7(`cap[4*idx+:4]`).
  - In SHOW with digit blanked: `digit` = onehot(`idx`), `seg` = all off.
  - In GAP: `digit` = all off, `seg` = all off.
  - `dp` is on only when in SHOW, `idx == 0` and `hold` is 1.
- **hex7 table** (active-high gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Reset** (`rst_n` = 0 at a clk edge):
  - `cap` = 0, `idx` = 0, `pre` = 0, `gc` = 0, state = SHOW.
  - `updated` = 0.
  - `seg`, `dp` and `digit` go to their inactive level after polarity applied, i.e. all ones for the default parameters.
  - Reset mid-scan abandons the current digit immediately.

## Timing
- Outputs lag the FSM state and `idx` by exactly 1 cycle, because of the output register.
- The first valid digit drive appears in the cycle after reset is released.
- Digit period is 2^SCAN_SHIFT + GAP_CYCLES cycles. Frame period is DIGITS times that.
- Capture to display:
  - `cap` updates 1 cycle after the `dataValid` edge.
  - The segment change is visible 1 cycle later, if `idx` is in SHOW at that point.
  - A change mid-SHOW updates the current digit immediately; no frame alignment is required.
- Simultaneous `dataValid` and `hold`: `hold` wins and there is no capture.
- `hold` and `blankEn` are combinational into next-output. Their changes take effect 1 cycle later.
- `updated` never fires for equal-value captures or while `hold` is 1.

## Structure
- Package `sm_display_pkg`: hex7 constant table, segment-off constant, state encoding (SHOW=0, GAP=1).
- Sub-module `sm_hex_to_seg`: combinational 4-bit to 7-bit decoder, active-high. Polarity is applied only in the top output register.
- Everything else (capture, FSM, counters, blanking priority encoder, output register) lives in `sm_hex_display_scan`.

## Test plan
All scenarios use SCAN_SHIFT=2, GAP_CYCLES=1, DIGITS=8 and active-high polarity unless noted.
- **Reset:** hold `rst_n` = 0 for 3 cycles, release. `digit`, `seg` and `dp` are 0 during reset. After release, `digit` = 0x01 in the 1st cycle, held 4 cycles, then 0x00 for 1 cycle, then 0x02.
- **Decode and scan:** `data` = 0x89ABCDEF with `dataValid` pulsed, `blankEn` = 0. Over one 40-cycle frame, digit0 shows `seg` = 0x71 (F) and digit7 shows 0x7F (8). Each digit is followed by a 1-cycle all-off gap.
- **Blanking:** `data` = 0x000000A0, `blankEn` = 1. Digits 0 and 1 drive 0x3F and 0x77; digits 2–7 have their `digit` bit set with `seg` = 0. With `data` = 0, only digit 0 shows 0x3F.
- **Hold and updated:** capture 0x12345678, then `hold` = 1 with `dataValid` = 1 and `data` = 0xFFFFFFFF. `cap` is unchanged, `updated` stays 0, and `dp` = 1 on digit 0. Release `hold`: next cycle `updated` = 1 for exactly one cycle.
- **Reset mid-operation:** assert `rst_n` = 0 during GAP of digit 5. Next cycle all outputs are off. After release the scan restarts at digit 0 and `cap` = 0.
- **Polarity:** with SEG_ACTIVE_LOW = 1 and DIGIT_ACTIVE_LOW = 1, `data` = 0 gives `seg` = 0x40 and `digit` = 0xFE on digit 0. During reset, `seg` = 0x7F and `digit` = 0xFF.
